// File: rtl/mtm_riscv_boot_flash_loader_if.sv
// rtl/mtm_riscv_boot_flash_loader_if.sv - SPI flash pins and code-RAM write port of the boot loader
interface mtm_riscv_boot_flash_loader_if #(
   parameter int ADDR_W = 12
);
   logic              spi_sclk;
   logic              spi_cs_n;
   logic              spi_mosi;
   logic              spi_miso;
   logic              ram_req;
   logic              ram_gnt;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;

   modport master (
      output spi_sclk, spi_cs_n, spi_mosi, ram_req, ram_addr, ram_wdata,
      input  spi_miso, ram_gnt
   );

   modport slave (
      input  spi_sclk, spi_cs_n, spi_mosi, ram_req, ram_addr, ram_wdata,
      output spi_miso, ram_gnt
   );
endinterface

// File: rtl/mtm_riscv_boot_flash_loader.sv
// rtl/mtm_riscv_boot_flash_loader.sv - SPI NOR (READ 0x03) boot image loader into code RAM
// Define BOOT_CHECKSUM_EN to read and verify a zero-sum trailer word after the image.
module mtm_riscv_boot_flash_loader #(
   parameter int          ADDR_W     = 12,
   parameter int          MAX_WORDS  = 4096,
   parameter int          CLK_DIV    = 2,
   parameter logic [23:0] FLASH_BASE = 24'h000000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   mtm_riscv_boot_flash_loader_if.master bus,
   output logic                         core_rst_n,
   output logic                         boot_sequence_done,
   output logic                         boot_error
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CMD   = 3'd1;
   localparam logic [2:0] S_HDR   = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_CSUM  = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;
   localparam logic [2:0] S_ERROR = 3'd7;

   localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [2:0]       state;
   logic [DIV_W-1:0] div_cnt;
   logic [4:0]       bit_cnt;
   logic [31:0]      cmd_sr;
   logic [31:0]      rx_sr;
   logic [ADDR_W:0]  index;
   logic [ADDR_W:0]  n_words;
   logic [ADDR_W:0]  index_nxt;
   logic [31:0]      rx_word;
   logic             shifting;
   logic             tick;
   logic             rise;
   logic             fall;
   logic             last_bit;
`ifdef BOOT_CHECKSUM_EN
   logic [31:0]      csum;
`endif

   // SCLK only runs in the shifting states; WRITE parks it low with the divider cleared
   assign shifting  = (state == S_CMD) || (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
   assign tick      = shifting && (div_cnt == DIV_LAST);
   assign rise      = tick && !bus.spi_sclk;
   assign fall      = tick && bus.spi_sclk;
   assign last_bit  = (bit_cnt == 5'd31);
   assign index_nxt = index + (ADDR_W+1)'(1);
   // bytes arrive MSB first, first byte is the least significant
   assign rx_word   = {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= S_IDLE;
         div_cnt            <= '0;
         bit_cnt            <= '0;
         cmd_sr             <= '0;
         rx_sr              <= '0;
         index              <= '0;
         n_words            <= '0;
         bus.spi_sclk       <= 1'b0;
         bus.spi_cs_n       <= 1'b1;
         bus.spi_mosi       <= 1'b0;
         bus.ram_req        <= 1'b0;
         bus.ram_addr       <= '0;
         bus.ram_wdata      <= '0;
         core_rst_n         <= 1'b0;
         boot_sequence_done <= 1'b0;
         boot_error         <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         csum               <= '0;
`endif
      end else begin
         if (!shifting || tick) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end

         if (rise) begin
            bus.spi_sclk <= 1'b1;
            if (state != S_CMD) begin
               rx_sr <= {rx_sr[30:0], bus.spi_miso};
            end
         end else if (fall) begin
            bus.spi_sclk <= 1'b0;
            bit_cnt      <= bit_cnt + 5'd1;
         end

         case (state)
            S_IDLE: begin
               bus.spi_cs_n <= 1'b0;
               cmd_sr       <= {8'h03, FLASH_BASE};
               bus.spi_mosi <= 1'b0;
               bit_cnt      <= '0;
               index        <= '0;
               state        <= S_CMD;
            end
            S_CMD: begin
               if (fall) begin
                  cmd_sr       <= {cmd_sr[30:0], 1'b0};
                  bus.spi_mosi <= last_bit ? 1'b0 : cmd_sr[30];
                  if (last_bit) begin
                     state <= S_HDR;
                  end
               end else if (tick && bit_cnt == 5'd0 && !bus.spi_sclk) begin
                  bus.spi_mosi <= cmd_sr[31];
               end
            end
            S_HDR: begin
               if (fall && last_bit) begin
                  if (rx_word == 32'd0 || rx_word > 32'(MAX_WORDS)) begin
                     bus.spi_cs_n <= 1'b1;
                     boot_error   <= 1'b1;
                     state        <= S_ERROR;
                  end else begin
                     n_words <= rx_word[ADDR_W:0];
                     state   <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (fall && last_bit) begin
                  bus.ram_req   <= 1'b1;
                  bus.ram_addr  <= index[ADDR_W-1:0];
                  bus.ram_wdata <= rx_word;
`ifdef BOOT_CHECKSUM_EN
                  csum          <= csum + rx_word;
`endif
                  state         <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (bus.ram_gnt) begin
                  bus.ram_req <= 1'b0;
                  index       <= index_nxt;
                  if (index_nxt == n_words) begin
`ifdef BOOT_CHECKSUM_EN
                     state <= S_CSUM;
`else
                     bus.spi_cs_n       <= 1'b1;
                     core_rst_n         <= 1'b1;
                     boot_sequence_done <= 1'b1;
                     state              <= S_DONE;
`endif
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_CSUM: begin
`ifdef BOOT_CHECKSUM_EN
               if (fall && last_bit) begin
                  bus.spi_cs_n <= 1'b1;
                  if (csum + rx_word == 32'd0) begin
                     core_rst_n         <= 1'b1;
                     boot_sequence_done <= 1'b1;
                     state              <= S_DONE;
                  end else begin
                     boot_error <= 1'b1;
                     state      <= S_ERROR;
                  end
               end
`else
               state <= S_ERROR;
`endif
            end
            S_DONE: begin
               state <= S_DONE;
            end
            default: begin
               state <= S_ERROR;
            end
         endcase
      end
   end
endmodule
